// File: rtl/word65_tx.sv
// Byte-serial unload port for the 65-bit result register: captures one word
// and emits it as a 10-byte frame (header, 8 payload bytes MSB first, XOR checksum).
module word65_tx (
    input  logic        clk,
    input  logic        clr,
    input  logic [64:0] ld_data,
    input  logic        ld_valid,
    output logic        ld_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic [1:0]  state_dbg
);

    localparam logic [6:0] HDR_TAG = 7'h55;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2,
        SUM  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [64:0] hold_q, hold_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  sum_q, sum_d;

    logic [7:0]  header;
    logic [63:0] payload_shift;
    logic [7:0]  payload_byte;
    logic        tx_accept;

    // Handshakes: a transfer happens on a cycle where valid and ready are both
    // high; the producer holds valid and data stable until that cycle.
    assign header        = {HDR_TAG, hold_q[64]};
    assign payload_shift = hold_q[63:0] << {idx_q, 3'b000};
    assign payload_byte  = payload_shift[63:56];
    assign tx_accept     = tx_valid & tx_ready;
    assign busy          = (state_q != IDLE);
    assign state_dbg     = state_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            hold_q  <= '0;
            idx_q   <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        idx_d    = idx_q;
        sum_d    = sum_q;
        ld_ready = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        case (state_q)
            IDLE: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    hold_d  = ld_data;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = HDR;
                end
            end
            HDR: begin
                tx_valid = 1'b1;
                tx_data  = header;
                if (tx_accept) begin
                    sum_d   = sum_q ^ header;
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                tx_valid = 1'b1;
                tx_data  = payload_byte;
                if (tx_accept) begin
                    sum_d = sum_q ^ payload_byte;
                    if (idx_q == 3'd7) begin
                        state_d = SUM;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            SUM: begin
                tx_valid = 1'b1;
                tx_data  = sum_q;
                if (tx_accept) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: doc/word65_tx.md
# word65_tx

Byte-serial transmitter that unloads a 65-bit result word (bit 64 = flag, bits 63:0 = payload) from the miner datapath and emits it as a framed byte stream toward the host link. It is the read/unload end of the 65-bit result register: the core writes the register, and this block captures one word per frame and serializes it under a valid/ready handshake. It sits between the result register and the byte-oriented host transmitter.

## Interface
- HDR_TAG, 7'h55, upper 7 bits of the header byte; header = {HDR_TAG, flag}.
- clk  input  1  rising-edge clock.
- clr  input  1  reset; synchronous, active-high; single clock domain, one clock only.
- ld_data  input  65  word to send; bit 64 = flag, bits 63:0 = payload.
- ld_valid  input  1  ld_data is valid.
- ld_ready  output  1  block can capture a word; high only in IDLE.
- tx_data  output  8  current frame byte.
- tx_valid  output  1  tx_data is valid.
- tx_ready  input  1  downstream accepts tx_data this cycle.
- busy  output  1  frame in progress (state != IDLE).

## Operation
- Frame: 10 bytes. Header {HDR_TAG, ld_data[64]}, then payload bytes [63:56] down to [7:0] (MSB byte first), then checksum = XOR of header and all 8 payload bytes.
- States: IDLE, HDR, DATA, SUM.
  - IDLE: ld_ready=1, tx_valid=0. On ld_valid & ld_ready, capture ld_data into an internal 65-bit hold register, clear byte index and checksum accumulator, go to HDR.
  - HDR: tx_valid=1, tx_data=header. On accept (tx_valid & tx_ready), fold header into checksum, index=0, go to DATA.
  - DATA: tx_valid=1, tx_data=payload byte[index]. On accept, fold byte into checksum; if index==7, go to SUM, else index+1.
  - SUM: tx_valid=1, tx_data=checksum. On accept, go to IDLE.
- ld_valid outside IDLE is ignored; the hold register is unchanged and ld_data may change freely.
- Byte index is 3 bits, counts 0..7, no wrap beyond 7.
- Checksum is an 8-bit XOR accumulator, reset to 0 at capture.

## Timing
- Reset values: ld_ready=1, tx_valid=0, tx_data=8'h00, busy=0, state=IDLE, index=0, checksum=0, hold register=0.
- clr mid-frame aborts: the cycle after clr is sampled high, all outputs hold reset values. No partial frame is resumed.
- Capture in cycle N puts the header on tx_data with tx_valid=1 in cycle N+1.
- With tx_ready held high, one byte is accepted per cycle, 10 cycles per frame. The last byte is accepted in cycle N+10, and ld_ready=1 in N+11.
- Back-to-back frames have a 1-cycle gap: the minimum period is 11 cycles from capture to capture.
- Back-pressure: while tx_valid & !tx_ready, tx_data, state, index and checksum hold stable. tx_valid never deasserts mid-frame.
- tx_ready while tx_valid=0 has no effect.
- ld_ready and tx_valid are never both high.

## Test plan
- Reset, then load ld_data=65'h1_0123456789ABCDEF with tx_ready=1 -> bytes AB 01 23 45 67 89 AB CD EF AB on consecutive cycles starting 1 cycle after capture; busy high for 10 cycles.
- Load 65'h0_0000000000000000 -> bytes AA, 00 ×8, AA.
- Same word as the first case with tx_ready toggled 1,0,0,1,0,… -> identical byte sequence; tx_data stable during every stall; 10 accepts total.
- Assert ld_valid with a different word during a frame -> ignored; the current frame is unchanged; the new word is captured only once ld_ready=1.
- Assert clr after the 4th data byte -> next cycle tx_valid=0, ld_ready=1, busy=0. A fresh load then yields a complete correct frame, with the checksum unaffected by the aborted frame.
- Keep ld_valid and tx_ready high with two words -> second header appears exactly 11 cycles after the first.
